sss_detect_ctrl: RTL and testbench

//  Sequences one SSS detection per PSS hit. Gets N_id_2 from the PSS stage and counts OFDM symbols to the SSS symbol.

---
 rtl/sss_detect_ctrl_pkg.sv | 23 ++
 rtl/sss_detect_ctrl_if.sv | 44 ++++
 rtl/sss_detect_ctrl_sc_gate.sv | 49 ++++
 rtl/sss_detect_ctrl.sv | 146 ++++++++++++++
 tb/tb_sss_detect_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sss_detect_ctrl_pkg.sv
// Shared types and constants for the SSS detection controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package sss_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYM,
    CAPTURE,
    WAIT_RES
  } state_t;

  localparam int SSS_LEN    = 127;  // SSS length in subcarriers
  localparam int N_ID_1_MAX = 335;  // largest legal N_id_1
  localparam int N_ID_W     = 10;   // width of N_id (0..1007)

  // N_id = 3*N_id_1 + N_id_2; fits 10 bits for every legal N_id_1.
  function automatic logic [N_ID_W-1:0] calc_n_id(input logic [8:0] n_id_1,
                                                  input logic [1:0] n_id_2);
    return N_ID_W'(n_id_1) * N_ID_W'(3) + N_ID_W'(n_id_2);
  endfunction

endpackage

// File: rtl/sss_detect_ctrl_if.sv
// Bundles the PSS result, subcarrier stream, SSS detector link and result outputs.
// Latency: n/a (wiring only).
// Backpressure: none; every stream here is valid-only.
interface sss_detect_ctrl_if
  import sss_ctrl_pkg::*;
#(
  parameter int N_ID_1_W = 9
);

  logic [1:0]          N_id_2_i;
  logic                N_id_2_valid_i;
  logic                s_axis_in_tdata;
  logic                s_axis_in_tvalid;
  logic                s_axis_in_tlast;
  logic [1:0]          det_N_id_2_o;
  logic                det_N_id_2_valid_o;
  logic                det_tdata_o;
  logic                det_tvalid_o;
  logic [N_ID_1_W-1:0] det_N_id_1_i;
  logic                det_valid_i;
  logic [N_ID_W-1:0]   m_axis_out_tdata;
  logic                m_axis_out_tvalid;
  logic                busy_o;
  logic                err_o;

  // Controller side.
  modport slave (
    input  N_id_2_i, N_id_2_valid_i,
    input  s_axis_in_tdata, s_axis_in_tvalid, s_axis_in_tlast,
    output det_N_id_2_o, det_N_id_2_valid_o, det_tdata_o, det_tvalid_o,
    input  det_N_id_1_i, det_valid_i,
    output m_axis_out_tdata, m_axis_out_tvalid, busy_o, err_o
  );

  // Environment side (PSS stage, demapper and SSS detector).
  modport master (
    output N_id_2_i, N_id_2_valid_i,
    output s_axis_in_tdata, s_axis_in_tvalid, s_axis_in_tlast,
    input  det_N_id_2_o, det_N_id_2_valid_o, det_tdata_o, det_tvalid_o,
    output det_N_id_1_i, det_valid_i,
    input  m_axis_out_tdata, m_axis_out_tvalid, busy_o, err_o
  );

endinterface

// File: rtl/sss_detect_ctrl_sc_gate.sv
// Subcarrier counter with SSS window compare; flags forwarded bits and a complete SSS.
// Latency: fwd_o/full_o are combinational on the current sample.
// Backpressure: none; counts every valid sample while enabled, saturating at SC_PER_SYM.
module sss_sc_gate
  import sss_ctrl_pkg::*;
#(
  parameter int SC_PER_SYM = 240,
  parameter int SSS_START  = 56
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  input  logic vld_i,
  output logic fwd_o,
  output logic full_o
);

  localparam int SC_W    = $clog2(SC_PER_SYM + 1);
  localparam int SSS_END = SSS_START + SSS_LEN - 1;

  logic [SC_W-1:0] sc_cnt_q, sc_cnt_d;
  logic [7:0]      fwd_cnt_q, fwd_cnt_d;
  logic            step;
  logic            in_win;

  // Window decode; full_o already counts the sample on the bus this cycle so
  // a tlast on the final SSS subcarrier is seen as complete.
  always_comb begin
    step      = en_i && vld_i && (int'(sc_cnt_q) < SC_PER_SYM);
    in_win    = (int'(sc_cnt_q) >= SSS_START) && (int'(sc_cnt_q) <= SSS_END);
    fwd_o     = step && in_win;
    sc_cnt_d  = step ? sc_cnt_q + SC_W'(1) : sc_cnt_q;
    fwd_cnt_d = fwd_cnt_q + {7'd0, fwd_o};
    full_o    = (int'(fwd_cnt_d) == SSS_LEN);
  end

  // Counters restart whenever the controller is not capturing.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      sc_cnt_q  <= '0;
      fwd_cnt_q <= '0;
    end else begin
      sc_cnt_q  <= sc_cnt_d;
      fwd_cnt_q <= fwd_cnt_d;
    end
  end

endmodule

// File: rtl/sss_detect_ctrl.sv
// Sequences one SSS detection per PSS hit and emits N_id; optional WAIT_RES timeout via SSS_CTRL_TIMEOUT_EN.
// Latency: det bits 1 cycle after input sample; N_id / err 1 cycle after det_valid_i or closing tlast.
// Backpressure: none; PSS hits and detector results arriving outside their state are dropped.
module sss_detect_ctrl
  import sss_ctrl_pkg::*;
#(
  parameter int SYM_OFFSET     = 2,     // must be >= 2
  parameter int SC_PER_SYM     = 240,
  parameter int SSS_START      = 56,
  parameter int N_ID_1_W       = 9,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk_i,
  input  logic                reset_i,
  sss_detect_ctrl_if.slave    bus
);

  localparam int SYM_W = $clog2(SYM_OFFSET + 1);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYM_OFFSET - 1);

  state_t              state_q;
  logic [1:0]          nid2_q;
  logic [SYM_W-1:0]    sym_cnt_q;
  logic [1:0]          det_n2_q;
  logic                det_n2_vld_q;
  logic                det_tdata_q;
  logic                det_tvalid_q;
  logic [N_ID_W-1:0]   out_tdata_q;
  logic                out_tvalid_q;
  logic                err_q;

  logic [N_ID_1_W-1:0] n_id_1;
  logic                in_last;
  logic                sc_fwd;
  logic                sc_full;
  logic                to_expired;

  assign n_id_1  = bus.det_N_id_1_i;
  assign in_last = bus.s_axis_in_tvalid && bus.s_axis_in_tlast;

  sss_sc_gate #(
    .SC_PER_SYM (SC_PER_SYM),
    .SSS_START  (SSS_START)
  ) u_sc_gate (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (state_q != CAPTURE),
    .en_i    (state_q == CAPTURE),
    .vld_i   (bus.s_axis_in_tvalid),
    .fwd_o   (sc_fwd),
    .full_o  (sc_full)
  );

`ifdef SSS_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  // Result-wait timer; held at zero outside WAIT_RES so every entry starts fresh.
  always_ff @(posedge clk_i) begin
    if (reset_i || state_q != WAIT_RES) to_cnt_q <= '0;
    else                                to_cnt_q <= to_cnt_q + TO_W'(1);
  end

  assign to_expired = (int'(to_cnt_q) == TIMEOUT_CYCLES - 1);
`else
  // No timer: WAIT_RES waits for the detector indefinitely.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_expired     = 1'b0;
`endif

  // Job sequencer; all outputs are registered here, pulses default low each cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      nid2_q       <= '0;
      sym_cnt_q    <= '0;
      det_n2_q     <= '0;
      det_n2_vld_q <= 1'b0;
      det_tdata_q  <= 1'b0;
      det_tvalid_q <= 1'b0;
      out_tdata_q  <= '0;
      out_tvalid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      det_n2_vld_q <= 1'b0;
      out_tvalid_q <= 1'b0;
      err_q        <= 1'b0;
      det_tvalid_q <= sc_fwd;
      det_tdata_q  <= sc_fwd & bus.s_axis_in_tdata;
      unique case (state_q)
        IDLE: begin
          if (bus.N_id_2_valid_i && bus.N_id_2_i != 2'd3) begin
            nid2_q       <= bus.N_id_2_i;
            det_n2_q     <= bus.N_id_2_i;
            det_n2_vld_q <= 1'b1;
            sym_cnt_q    <= '0;
            state_q      <= WAIT_SYM;
          end
        end
        WAIT_SYM: begin
          if (in_last) begin
            sym_cnt_q <= sym_cnt_q + SYM_W'(1);
            if (sym_cnt_q + SYM_W'(1) == SYM_LAST) state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (in_last) begin
            if (sc_full) begin
              state_q <= WAIT_RES;
            end else begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        WAIT_RES: begin
          // A detector result wins over a same-cycle timeout.
          if (bus.det_valid_i) begin
            if (int'(n_id_1) > N_ID_1_MAX) begin
              err_q <= 1'b1;
            end else begin
              out_tdata_q  <= calc_n_id(9'(n_id_1), nid2_q);
              out_tvalid_q <= 1'b1;
            end
            state_q <= IDLE;
          end else if (to_expired) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.det_N_id_2_o       = det_n2_q;
  assign bus.det_N_id_2_valid_o = det_n2_vld_q;
  assign bus.det_tdata_o        = det_tdata_q;
  assign bus.det_tvalid_o       = det_tvalid_q;
  assign bus.m_axis_out_tdata   = out_tdata_q;
  assign bus.m_axis_out_tvalid  = out_tvalid_q;
  assign bus.busy_o             = (state_q != IDLE);
  assign bus.err_o              = err_q;

endmodule

// File: tb/tb_sss_detect_ctrl.sv
// Self-checking bench for sss_detect_ctrl: job table plus hand-written corner sequences.
// Expected output events are queued with their due cycle and matched as the DUT emits them.
// Timeout scenario is exercised when SSS_CTRL_TIMEOUT_EN is defined.
module tb_sss_detect_ctrl;
  import sss_ctrl_pkg::*;

  localparam int TIMEOUT = 64;
  localparam int K_N2 = 0, K_BIT = 1, K_OUT = 2, K_ERR = 3;
  localparam int R_OUT = 1, R_BADN1 = 2, R_SHORT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sss_detect_ctrl_if #(.N_ID_1_W(9)) bus();

  sss_detect_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  typedef struct {
    int kind;
    int v;
    int c;
  } exp_t;

  typedef struct {
    logic [1:0] n2;
    logic [8:0] n1;
    int         sss_len;
    int         res;
    int         exp_nid;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   bit_pulses = 0;
  bit   mon_en = 1'b0;

  task automatic check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic string kname(int k);
    case (k)
      K_N2:    return "det_n2";
      K_BIT:   return "det_bit";
      K_OUT:   return "n_id_out";
      default: return "err";
    endcase
  endfunction

  task automatic expect_ev(int k, int v);
    sb.push_back('{k, v, cyc + 1});
  endtask

  // Match this cycle's output pulses against the oldest pending expectation of each kind.
  task automatic monitor();
    bit seen;
    int val;
    int idx;
    for (int k = 0; k < 4; k++) begin
      case (k)
        K_N2:    begin seen = bus.det_N_id_2_valid_o; val = int'(bus.det_N_id_2_o);    end
        K_BIT:   begin seen = bus.det_tvalid_o;       val = int'(bus.det_tdata_o);     end
        K_OUT:   begin seen = bus.m_axis_out_tvalid;  val = int'(bus.m_axis_out_tdata); end
        default: begin seen = bus.err_o;              val = 1;                         end
      endcase
      idx = -1;
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].kind == k) begin
          idx = i;
          break;
        end
      end
      if (seen) begin
        if (k == K_BIT) bit_pulses++;
        if (idx < 0) begin
          flag_fail({kname(k), " unexpected pulse"});
        end else begin
          check(kname(k), val, sb[idx].v);
          check({kname(k), "_cycle"}, cyc, sb[idx].c);
          sb.delete(idx);
        end
      end else if (idx >= 0 && sb[idx].c <= cyc) begin
        flag_fail({kname(k), " missing pulse"});
        sb.delete(idx);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (mon_en) monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_pss(logic [1:0] n2, bit accept);
    bus.N_id_2_i       = n2;
    bus.N_id_2_valid_i = 1'b1;
    if (accept) expect_ev(K_N2, int'(n2));
    step();
    bus.N_id_2_valid_i = 1'b0;
    bus.N_id_2_i       = 2'd0;
  endtask

  // One symbol of len samples with tlast on the last; cut >= 0 stops early
  // without tlast; pss_at raises a (to-be-dropped) PSS hit on that sample.
  task automatic send_sym(int len, bit sss, int cut, int pss_at);
    int fwd;
    fwd = 0;
    for (int s = 0; s < len; s++) begin
      if (cut >= 0 && s == cut) break;
      if ($urandom_range(0, 7) == 0) begin
        bus.s_axis_in_tvalid = 1'b0;
        step();
      end
      bus.s_axis_in_tvalid = 1'b1;
      bus.s_axis_in_tdata  = 1'($urandom_range(0, 1));
      bus.s_axis_in_tlast  = (s == len - 1);
      if (s == pss_at) begin
        bus.N_id_2_valid_i = 1'b1;
        bus.N_id_2_i       = 2'd2;
      end
      if (sss && s >= 56 && s <= 182) begin
        expect_ev(K_BIT, int'(bus.s_axis_in_tdata));
        fwd++;
      end
      if (sss && s == len - 1 && fwd != 127) expect_ev(K_ERR, 1);
      step();
      bus.N_id_2_valid_i = 1'b0;
    end
    bus.s_axis_in_tvalid = 1'b0;
    bus.s_axis_in_tlast  = 1'b0;
    bus.s_axis_in_tdata  = 1'b0;
  endtask

  // res: 0 = must be ignored, R_OUT = N_id expected, otherwise err expected.
  task automatic send_det(logic [8:0] n1, int res, int exp_nid, bit with_pss);
    bus.det_N_id_1_i = n1;
    bus.det_valid_i  = 1'b1;
    if (with_pss) begin
      bus.N_id_2_valid_i = 1'b1;
      bus.N_id_2_i       = 2'd0;
    end
    if (res == R_OUT)  expect_ev(K_OUT, exp_nid);
    else if (res != 0) expect_ev(K_ERR, 1);
    step();
    bus.det_valid_i    = 1'b0;
    bus.N_id_2_valid_i = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_busy"},        int'(bus.busy_o), 0);
    check({tag, "_err"},         int'(bus.err_o), 0);
    check({tag, "_det_tvalid"},  int'(bus.det_tvalid_o), 0);
    check({tag, "_det_n2_vld"},  int'(bus.det_N_id_2_valid_o), 0);
    check({tag, "_out_tvalid"},  int'(bus.m_axis_out_tvalid), 0);
    check({tag, "_out_tdata"},   int'(bus.m_axis_out_tdata), 0);
  endtask

  initial begin
    vecs[0] = '{2'd1, 9'd100, 240, R_OUT,   301};
    vecs[1] = '{2'd0, 9'd0,   240, R_OUT,   0};
    vecs[2] = '{2'd2, 9'd335, 240, R_OUT,   1007};
    vecs[3] = '{2'd2, 9'd336, 240, R_BADN1, 0};
    vecs[4] = '{2'd0, 9'd50,  101, R_SHORT, 0};
    vecs[5] = '{2'd1, 9'd5,   183, R_OUT,   16};
    vecs[6] = '{2'd2, 9'd511, 240, R_BADN1, 0};
    vecs[7] = '{2'd0, 9'd7,   300, R_OUT,   21};
    vecs[8] = '{2'd1, 9'd200, 182, R_SHORT, 0};

    rst                  = 1'b1;
    bus.N_id_2_i         = 2'd0;
    bus.N_id_2_valid_i   = 1'b0;
    bus.s_axis_in_tdata  = 1'b0;
    bus.s_axis_in_tvalid = 1'b0;
    bus.s_axis_in_tlast  = 1'b0;
    bus.det_N_id_1_i     = 9'd0;
    bus.det_valid_i      = 1'b0;
    idle(3);
    check_all_zero("reset");
    rst    = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Table of complete jobs.
    for (int t = 0; t < 9; t++) begin
      bit_pulses = 0;
      send_pss(vecs[t].n2, 1'b1);
      idle(2);
      send_sym(240, 1'b0, -1, -1);
      send_sym(vecs[t].sss_len, 1'b1, -1, -1);
      check($sformatf("v%0d_busy_after_sss", t), int'(bus.busy_o),
            (vecs[t].res == R_SHORT) ? 0 : 1);
      step();
      if (vecs[t].res != R_SHORT) begin
        check($sformatf("v%0d_bit_pulses", t), bit_pulses, 127);
        idle(3);
        send_det(vecs[t].n1, vecs[t].res, vecs[t].exp_nid, 1'b0);
        check($sformatf("v%0d_busy_after_det", t), int'(bus.busy_o), 0);
      end
      idle(2);
    end

    // N_id_2 == 3 is not a PSS hit; a stray detector result in IDLE is ignored.
    send_pss(2'd3, 1'b0);
    check("nid2_3_busy", int'(bus.busy_o), 0);
    send_det(9'd10, 0, 0, 1'b0);
    idle(2);
    check("nid2_3_busy_later", int'(bus.busy_o), 0);

    // Extra PSS hits while busy are dropped; stray det_valid in WAIT_SYM ignored.
    send_pss(2'd1, 1'b1);
    send_det(9'd5, 0, 0, 1'b0);
    send_sym(240, 1'b0, -1, 100);
    send_sym(240, 1'b1, -1, 30);
    step();
    send_det(9'd100, R_OUT, 301, 1'b0);
    idle(2);

    // Result and PSS together in WAIT_RES, then a PSS right after the result pulse.
    send_pss(2'd2, 1'b1);
    send_sym(240, 1'b0, -1, -1);
    send_sym(240, 1'b1, -1, -1);
    step();
    send_det(9'd20, R_OUT, 62, 1'b1);
    send_pss(2'd0, 1'b1);
    send_sym(240, 1'b0, -1, -1);
    send_sym(240, 1'b1, -1, -1);
    step();
    send_det(9'd1, R_OUT, 3, 1'b0);
    idle(2);

    // Long wait for the detector result.
    send_pss(2'd1, 1'b1);
    send_sym(240, 1'b0, -1, -1);
    send_sym(240, 1'b1, -1, -1);
`ifdef SSS_CTRL_TIMEOUT_EN
    sb.push_back('{K_ERR, 1, cyc + TIMEOUT});
    idle(TIMEOUT + 3);
    check("timeout_busy", int'(bus.busy_o), 0);
`else
    idle(150);
    check("no_timeout_busy", int'(bus.busy_o), 1);
    send_det(9'd300, R_OUT, 901, 1'b0);
`endif
    idle(2);

    // Reset in the middle of CAPTURE aborts silently.
    send_pss(2'd0, 1'b1);
    send_sym(240, 1'b0, -1, -1);
    send_sym(240, 1'b1, 80, -1);
    rst = 1'b1;
    step();
    check_all_zero("midreset");
    rst = 1'b0;
    idle(3);
    send_pss(2'd2, 1'b1);
    send_sym(240, 1'b0, -1, -1);
    send_sym(240, 1'b1, -1, -1);
    step();
    send_det(9'd10, R_OUT, 32, 1'b0);
    idle(3);

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
